// File: rtl/pll_lock_sequencer_if.sv
// Sequencer <-> PLL / processor-reset signal bundle.
// master: the sequencer; slave: the PLL and reset consumers (or a testbench).
interface pll_lock_sequencer_if;
  logic       pll_lock;
  logic       pll_resetb;
  logic       pll_bypass;
  logic       sys_rst_n;
  logic       locked;
  logic       fail;
  logic [3:0] retry_cnt;

  modport master (
    input  pll_lock,
    output pll_resetb, pll_bypass, sys_rst_n, locked, fail, retry_cnt
  );

  modport slave (
    output pll_lock,
    input  pll_resetb, pll_bypass, sys_rst_n, locked, fail, retry_cnt
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// iCE40 PLL power-up/recovery sequencer: holds the PLL in reset, waits for stable lock, then releases sys_rst_n.
// Optional feature macro PLL_BYPASS_FALLBACK_EN: on retry exhaustion run from the reference clock via PLL bypass.
module pll_lock_sequencer #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 4800,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  pll_lock_sequencer_if.master seq
);
  localparam int CNT_MAX0 = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX  = (CNT_MAX0 > STABLE_CYCLES) ? CNT_MAX0 : STABLE_CYCLES;
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RESET_LOAD   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL,
    BYPASS
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0]       retry_nxt;
  logic             sync1;
  logic             lock_s;
  logic             cnt_done;

  assign cnt_done = (cnt == '0);

  always_comb begin
    state_nxt = state;
    retry_nxt = seq.retry_cnt;
    cnt_nxt   = cnt_done ? cnt : cnt - CNT_W'(1);
    case (state)
      RESET_PLL: if (cnt_done) state_nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        // Lock has priority over a timeout landing in the same cycle.
        if (lock_s) begin
          state_nxt = STABLE;
        end else if (cnt_done) begin
          if (seq.retry_cnt == RETRY_LIMIT) begin
`ifdef PLL_BYPASS_FALLBACK_EN
            state_nxt = BYPASS;
`else
            state_nxt = FAIL;
`endif
          end else begin
            state_nxt = RESET_PLL;
            if (seq.retry_cnt != 4'hF) retry_nxt = seq.retry_cnt + 4'd1;
          end
        end
      end
      STABLE: begin
        if (!lock_s)       state_nxt = WAIT_LOCK;
        else if (cnt_done) state_nxt = RUN;
      end
      RUN:     if (!lock_s) state_nxt = RESET_PLL;
      default: ;
    endcase

    if (state_nxt != state) begin
      case (state_nxt)
        WAIT_LOCK: cnt_nxt = TIMEOUT_LOAD;
        STABLE:    cnt_nxt = STABLE_LOAD;
        RUN: begin
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
        default:   cnt_nxt = RESET_LOAD;
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= RESET_PLL;
      cnt            <= RESET_LOAD;
      sync1          <= 1'b0;
      lock_s         <= 1'b0;
      seq.pll_resetb <= 1'b0;
      seq.pll_bypass <= 1'b0;
      seq.sys_rst_n  <= 1'b0;
      seq.locked     <= 1'b0;
      seq.fail       <= 1'b0;
      seq.retry_cnt  <= '0;
    end else begin
      sync1          <= seq.pll_lock;
      lock_s         <= sync1;
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      seq.retry_cnt  <= retry_nxt;
      seq.pll_resetb <= !((state_nxt == RESET_PLL) || (state_nxt == FAIL));
      seq.sys_rst_n  <= (state_nxt == RUN) ||
                        ((state_nxt == BYPASS) && (state == BYPASS) && cnt_done);
      seq.locked     <= (state_nxt == RUN);
      seq.fail       <= (state_nxt == FAIL) || (state_nxt == BYPASS);
`ifdef PLL_BYPASS_FALLBACK_EN
      seq.pll_bypass <= (state_nxt == BYPASS);
`else
      seq.pll_bypass <= 1'b0;
`endif
    end
  end
endmodule
